// File: rtl/mdu_pkg.sv
// mdu_pkg: shared width, op encoding, FSM states and operand-magnitude helper for the MDU
package mdu_pkg;
  localparam int W = 32;
  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic is_signed);
    return (is_signed & x[W-1]) ? -x : x;
  endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the register bank side and the MDU
interface mdu_if;
  import mdu_pkg::*;
  logic start;
  logic [2:0] op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic busy;
  logic done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  modport master (output start, op, A, B, input busy, done, hi, lo);
  modport slave (input start, op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/mdu.sv
// mdu: iterative shift-add multiplier / restoring divider holding HI and LO
module mdu
  import mdu_pkg::*;
(
  input logic clk,
  input logic rst_n,
  mdu_if.slave bus
);
  localparam int CW = $clog2(W) + 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [W-1:0] opb, a_org;
  logic [2*W-1:0] acc;
  logic [W:0] rem;
  logic is_div, is_signed, sa, sb;
  logic [W:0] mul_sum, shl;
  logic ge, neg_q;
  logic [2*W-1:0] prod;
  logic [W-1:0] quo, rmd;
  // one datapath step: multiply adds into the upper half, divide trials the shifted remainder
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
    shl = {rem[W-1:0], acc[W-1]};
    ge = shl >= {1'b0, opb};
    neg_q = is_signed & (sa ^ sb);
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[W-1:0] : acc[W-1:0];
    rmd = (is_signed & sa) ? -rem[W-1:0] : rem[W-1:0];
  end
  // control FSM with registered busy/done and the architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      opb <= '0;
      a_org <= '0;
      acc <= '0;
      rem <= '0;
      is_div <= 1'b0;
      is_signed <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (bus.op == OP_MTHI) bus.hi <= bus.A;
          if (bus.op == OP_MTLO) bus.lo <= bus.A;
          if (!bus.op[2]) begin
            is_signed <= ~bus.op[0];
            is_div <= bus.op[1];
            sa <= ~bus.op[0] & bus.A[W-1];
            sb <= ~bus.op[0] & bus.B[W-1];
            opb <= mag(bus.B, ~bus.op[0]);
            acc <= {{W{1'b0}}, mag(bus.A, ~bus.op[0])};
            a_org <= bus.A;
            rem <= '0;
            cnt <= '0;
            state <= CALC;
            bus.busy <= 1'b1;
          end
        end
        CALC: begin
          if (is_div) begin
            rem <= ge ? shl - {1'b0, opb} : shl;
            acc[W-1:0] <= {acc[W-2:0], ge};
          end else acc <= {mul_sum, acc[W-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) {bus.hi, bus.lo} <= prod;
          else if (opb == '0) begin
            bus.hi <= a_org;
            bus.lo <= '1;
          end else begin
            bus.hi <= rmd;
            bus.lo <= quo;
          end
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed-vector self-checking bench for the iterative MDU
module tb_mdu;
  import mdu_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int pass = 0;
  int total = 0;
  mdu_if bus();
  mdu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int dcyc, output int ndone, output int busy_err, output int hold_err,
                       output logic [31:0] h, output logic [31:0] l);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
    dcyc = -1; ndone = 0; busy_err = 0; hold_err = 0; h = 'x; l = 'x;
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy !== (c <= 33)) busy_err++;
      if (c <= 33 && (bus.hi !== h0 || bus.lo !== l0)) hold_err++;
      if (bus.done === 1'b1) begin
        ndone++;
        if (dcyc < 0) begin dcyc = c; h = bus.hi; l = bus.lo; end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass++;
    total++; if (bus.hi !== 32'h0) $display("FAIL reset_hi got %h want 0", bus.hi); else pass++;
    total++; if (bus.lo !== 32'h0) $display("FAIL reset_lo got %h want 0", bus.lo); else pass++;
  endtask

  task automatic test_arith(input string name, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int dcyc, ndone, busy_err, hold_err;
    logic [31:0] h, l;
    do_op(o, a, b, dcyc, ndone, busy_err, hold_err, h, l);
    total++; if (dcyc !== 34) $display("FAIL %s_done_cycle got %0d want 34", name, dcyc); else pass++;
    total++; if (ndone !== 1) $display("FAIL %s_done_pulses got %0d want 1", name, ndone); else pass++;
    total++; if (busy_err !== 0) $display("FAIL %s_busy_window got %0d bad cycles want 0", name, busy_err); else pass++;
    total++; if (hold_err !== 0) $display("FAIL %s_hilo_hold got %0d bad cycles want 0", name, hold_err); else pass++;
    total++; if (h !== eh) $display("FAIL %s_hi got %h want %h", name, h, eh); else pass++;
    total++; if (l !== el) $display("FAIL %s_lo got %h want %h", name, l, el); else pass++;
  endtask

  task automatic test_move;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTLO; bus.A = 32'h12345678;
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.lo !== 32'h12345678) $display("FAIL mtlo_lo got %h want 12345678", bus.lo); else pass++;
    total++; if (bus.busy !== 1'b0) $display("FAIL mtlo_busy got %b want 0", bus.busy); else pass++;
    total++; if (bus.done !== 1'b0) $display("FAIL mtlo_done got %b want 0", bus.done); else pass++;
    bus.start = 1'b1; bus.op = OP_MTHI; bus.A = 32'hCAFEF00D;
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.hi !== 32'hCAFEF00D) $display("FAIL mthi_hi got %h want cafef00d", bus.hi); else pass++;
    total++; if (bus.lo !== 32'h12345678) $display("FAIL mthi_lo_kept got %h want 12345678", bus.lo); else pass++;
    bus.start = 1'b1; bus.op = 3'b110; bus.A = 32'hDEADBEEF;
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.hi !== 32'hCAFEF00D || bus.lo !== 32'h12345678 || bus.busy !== 1'b0)
      $display("FAIL noop_state got hi=%h lo=%h busy=%b want cafef00d/12345678/0", bus.hi, bus.lo, bus.busy); else pass++;
  endtask

  task automatic test_ignore_start;
    int dcyc = -1;
    int ndone = 0;
    logic [31:0] h = 'x, l = 'x;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.A = 32'd3; bus.B = 32'hFFFFFFFB;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      bus.start = (c == 10);
      if (c == 10) begin bus.op = OP_MULTU; bus.A = 32'd100; bus.B = 32'd100; end
      if (bus.done === 1'b1) begin
        ndone++;
        if (dcyc < 0) begin dcyc = c; h = bus.hi; l = bus.lo; end
      end
    end
    bus.start = 1'b0;
    total++; if (dcyc !== 34) $display("FAIL ignore_done_cycle got %0d want 34", dcyc); else pass++;
    total++; if (ndone !== 1) $display("FAIL ignore_done_pulses got %0d want 1", ndone); else pass++;
    total++; if (h !== 32'hFFFFFFFF) $display("FAIL ignore_hi got %h want ffffffff", h); else pass++;
    total++; if (l !== 32'hFFFFFFF1) $display("FAIL ignore_lo got %h want fffffff1", l); else pass++;
  endtask

  task automatic test_back_to_back;
    int dcyc = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.A = 32'd2; bus.B = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < 34; c++) @(negedge clk);
    total++; if (bus.done !== 1'b1 || bus.lo !== 32'd6) $display("FAIL b2b_first got done=%b lo=%h want 1/6", bus.done, bus.lo); else pass++;
    bus.start = 1'b1; bus.op = OP_MULTU; bus.A = 32'd4; bus.B = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", bus.busy); else pass++;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done === 1'b1 && dcyc < 0) dcyc = c;
      if (dcyc < 0) @(negedge clk);
    end
    total++; if (dcyc !== 34 || bus.lo !== 32'd20 || bus.hi !== 32'd0)
      $display("FAIL b2b_second got cycle=%0d hi=%h lo=%h want 34/0/14", dcyc, bus.hi, bus.lo); else pass++;
  endtask

  task automatic test_reset_abort;
    int ndone = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.A = 32'd100; bus.B = 32'd7;
    for (int c = 1; c < 15; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else pass++;
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) $display("FAIL abort_hilo got %h/%h want 0/0", bus.hi, bus.lo); else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 16; c <= 40; c++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) ndone++;
      @(negedge clk);
    end
    total++; if (ndone !== 0) $display("FAIL abort_quiet got %0d active cycles want 0", ndone); else pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 3'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_arith("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    test_arith("mult_neg", OP_MULT, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6);
    test_arith("mult_big", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    test_arith("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    test_arith("div_pos_neg", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    test_arith("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    test_arith("divu_zero", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    test_arith("div_zero_neg", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    test_arith("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    test_move();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_arith("multu_after_rst", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
